// File: rtl/mc_pkg.sv
// mc_pkg: encodings shared by the multicycle and pipelined MIPS-subset
// control units. It holds the opcode constants, the controller state codes
// and the ALU-op, ALU-B-select and PC-source field encodings.
package mc_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_NOP   = 6'b100000;
   localparam logic [5:0] OP_J     = 6'b000010;

   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_FETCH    = 4'd1,
      S_DECODE   = 4'd2,
      S_MEM_ADDR = 4'd3,
      S_MEM_RD   = 4'd4,
      S_MEM_WB   = 4'd5,
      S_MEM_WR   = 4'd6,
      S_EXEC     = 4'd7,
      S_R_WB     = 4'd8,
      S_BRANCH   = 4'd9,
      S_JUMP     = 4'd10
   } state_t;

   typedef enum logic [1:0] {
      ALU_ADD   = 2'b00,
      ALU_SUB   = 2'b01,
      ALU_FUNCT = 2'b10
   } alu_op_t;

   typedef enum logic [1:0] {
      SRCB_B       = 2'b00,
      SRCB_FOUR    = 2'b01,
      SRCB_IMM     = 2'b10,
      SRCB_IMM_SH2 = 2'b11
   } alu_src_b_t;

   typedef enum logic [1:0] {
      PCSRC_ALU    = 2'b00,
      PCSRC_ALUOUT = 2'b01,
      PCSRC_JUMP   = 2'b10
   } pc_source_t;

endpackage

// File: rtl/mc_control_wait_timer.sv
// mc_wait_timer: memory-wait watchdog counter.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (counter -> 0)
//   clear      : zero the counter on the next edge (wins over waiting)
//   waiting    : a cycle spent waiting for mem_ready; counter increments
//   expired    : waiting in the TIMEOUT-th consecutive wait cycle
// TIMEOUT = 0 disables the watchdog (expired is held 0).
module mc_wait_timer #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic waiting,
   output logic expired
);

   localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear)
         cnt_d = '0;
      else if (waiting)
         cnt_d = cnt_q + CW'(1);
   end

   // The counter is 0 in the first wait cycle, so TIMEOUT-1 marks the last one.
   always_comb begin
      expired = (TIMEOUT != 0) && waiting && (cnt_q == CW'(TIMEOUT - 1));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/mc_control.sv
// mc_control: multicycle controller FSM for the MIPS-subset datapath
// (RTYPE, LW, SW, BEQ, NOP; J when built with JUMP_EN defined).
//
// Ports:
//   clk, rst_n      : clock (rising edge), asynchronous active-low reset
//   opcode          : IR[31:26]
//   zero            : ALU zero flag (BEQ decision)
//   mem_ready       : memory completes the current access this cycle
//   pc_write, pc_source, iord, mem_read, mem_write, ir_write, reg_dst,
//   mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op : datapath controls
//   instr_done      : pulse when an instruction retires
//   illegal         : pulse on an unrecognised opcode in DECODE
//   mem_err         : pulse on a watchdog abort of a memory wait
//   retired         : retired-instruction count (wraps)
//   state           : current state code (debug)
// Parameters: TIMEOUT (memory-wait watchdog, 0 = off), RET_W (retired width).
// Build option: JUMP_EN enables the J instruction and the JUMP state.
module mc_control
   import mc_pkg::*;
#(
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned RET_W   = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [5:0]       opcode,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             pc_write,
   output logic             iord,
   output logic             mem_read,
   output logic             mem_write,
   output logic             ir_write,
   output logic             reg_dst,
   output logic             mem_to_reg,
   output logic             reg_write,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       alu_op,
   output logic [1:0]       pc_source,
   output logic             instr_done,
   output logic             illegal,
   output logic             mem_err,
   output logic [RET_W-1:0] retired,
   output logic [3:0]       state
);

   state_t           state_q, state_d;
   logic [RET_W-1:0] retired_q;
   logic             waiting, expired, tmr_clear;

   // Kept apart from the FSM block so that expired does not feed back into
   // the process that consumes it.
   assign waiting = ((state_q == S_FETCH) || (state_q == S_MEM_RD) ||
                     (state_q == S_MEM_WR)) && !mem_ready;

   // A timeout in FETCH stays in FETCH, so mem_err must clear explicitly.
   assign tmr_clear = (state_d != state_q) || mem_ready || mem_err;

   mc_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (tmr_clear),
      .waiting (waiting),
      .expired (expired)
   );

   always_comb begin
      state_d    = state_q;
      pc_write   = 1'b0;
      iord       = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = SRCB_B;
      alu_op     = ALU_ADD;
      pc_source  = PCSRC_ALU;
      instr_done = 1'b0;
      illegal    = 1'b0;
      mem_err    = 1'b0;
      case (state_q)
         S_IDLE: state_d = S_FETCH;
         S_FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = SRCB_FOUR;
            if (mem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               state_d  = S_DECODE;
            end else if (expired) begin
               mem_err = 1'b1;
            end
         end
         S_DECODE: begin
            alu_src_b = SRCB_IMM_SH2;
            case (opcode)
               OP_LW, OP_SW: state_d = S_MEM_ADDR;
               OP_RTYPE:     state_d = S_EXEC;
               OP_BEQ:       state_d = S_BRANCH;
               OP_NOP: begin
                  instr_done = 1'b1;
                  state_d    = S_FETCH;
               end
`ifdef JUMP_EN
               OP_J:         state_d = S_JUMP;
`endif
               default: begin
                  illegal = 1'b1;
                  state_d = S_FETCH;
               end
            endcase
         end
         S_MEM_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
            state_d   = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
         end
         S_MEM_RD: begin
            mem_read = 1'b1;
            iord     = 1'b1;
            if (mem_ready) begin
               state_d = S_MEM_WB;
            end else if (expired) begin
               mem_err = 1'b1;
               state_d = S_FETCH;
            end
         end
         S_MEM_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         S_MEM_WR: begin
            mem_write = 1'b1;
            iord      = 1'b1;
            if (mem_ready) begin
               instr_done = 1'b1;
               state_d    = S_FETCH;
            end else if (expired) begin
               mem_err = 1'b1;
               state_d = S_FETCH;
            end
         end
         S_EXEC: begin
            alu_src_a = 1'b1;
            alu_op    = ALU_FUNCT;
            state_d   = S_R_WB;
         end
         S_R_WB: begin
            reg_write  = 1'b1;
            reg_dst    = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a  = 1'b1;
            alu_op     = ALU_SUB;
            pc_source  = PCSRC_ALUOUT;
            pc_write   = zero;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
`ifdef JUMP_EN
         S_JUMP: begin
            pc_write   = 1'b1;
            pc_source  = PCSRC_JUMP;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
`endif
         default: state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         retired_q <= '0;
      end else begin
         state_q <= state_d;
         if (instr_done)
            retired_q <= retired_q + RET_W'(1);
      end
   end

   assign retired = retired_q;
   assign state   = state_q;

endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: directed self-checking bench for mc_control (TIMEOUT=4).
// Each step drives inputs after a rising edge, pushes the expected state,
// output vector and retired count to a scoreboard queue, and pops/compares
// on the following falling edge. Build with JUMP_EN to cover the J path.
module tb_mc_control;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [5:0]  opcode;
   logic        zero;
   logic        mem_ready;
   logic        pc_write, iord, mem_read, mem_write, ir_write, reg_dst;
   logic        mem_to_reg, reg_write, alu_src_a;
   logic [1:0]  alu_src_b, alu_op, pc_source;
   logic        instr_done, illegal, mem_err;
   logic [31:0] retired;
   logic [3:0]  state;

   mc_control #(.TIMEOUT(4), .RET_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero),
      .mem_ready(mem_ready), .pc_write(pc_write), .iord(iord),
      .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
      .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .pc_source(pc_source), .instr_done(instr_done), .illegal(illegal),
      .mem_err(mem_err), .retired(retired), .state(state)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       pc_write, iord, mem_read, mem_write, ir_write;
      logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
      logic [1:0] alu_src_b, alu_op, pc_source;
      logic       instr_done, illegal, mem_err;
   } outs_t;

   typedef struct packed {
      logic [3:0]  st;
      outs_t       o;
      logic [31:0] ret;
   } exp_t;

   outs_t obs;
   assign obs = {pc_write, iord, mem_read, mem_write, ir_write, reg_dst,
                 mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
                 pc_source, instr_done, illegal, mem_err};

   // Field order: pcw iord mrd mwr irw rdst m2r rw asa asb aop psrc idn ill merr
   localparam outs_t O_NONE = '0;
   localparam outs_t O_FW   = 18'b0_0_1_0_0_0_0_0_0_01_00_00_0_0_0;
   localparam outs_t O_FG   = 18'b1_0_1_0_1_0_0_0_0_01_00_00_0_0_0;
   localparam outs_t O_FT   = 18'b0_0_1_0_0_0_0_0_0_01_00_00_0_0_1;
   localparam outs_t O_DEC  = 18'b0_0_0_0_0_0_0_0_0_11_00_00_0_0_0;
   localparam outs_t O_NOP  = 18'b0_0_0_0_0_0_0_0_0_11_00_00_1_0_0;
   localparam outs_t O_ILL  = 18'b0_0_0_0_0_0_0_0_0_11_00_00_0_1_0;
   localparam outs_t O_MA   = 18'b0_0_0_0_0_0_0_0_1_10_00_00_0_0_0;
   localparam outs_t O_RD   = 18'b0_1_1_0_0_0_0_0_0_00_00_00_0_0_0;
   localparam outs_t O_WB   = 18'b0_0_0_0_0_0_1_1_0_00_00_00_1_0_0;
   localparam outs_t O_WR   = 18'b0_1_0_1_0_0_0_0_0_00_00_00_0_0_0;
   localparam outs_t O_WRG  = 18'b0_1_0_1_0_0_0_0_0_00_00_00_1_0_0;
   localparam outs_t O_WRT  = 18'b0_1_0_1_0_0_0_0_0_00_00_00_0_0_1;
   localparam outs_t O_EX   = 18'b0_0_0_0_0_0_0_0_1_00_10_00_0_0_0;
   localparam outs_t O_RW   = 18'b0_0_0_0_0_1_0_1_0_00_00_00_1_0_0;
   localparam outs_t O_B0   = 18'b0_0_0_0_0_0_0_0_1_00_01_01_1_0_0;
   localparam outs_t O_B1   = 18'b1_0_0_0_0_0_0_0_1_00_01_01_1_0_0;
   localparam outs_t O_J    = 18'b1_0_0_0_0_0_0_0_0_00_00_10_1_0_0;

   int          n_asrt = 0;
   int          n_fail = 0;
   logic [31:0] ret_m  = '0;
   exp_t        sb[$];

   task automatic chk(input string tag, input logic [31:0] o_v, input logic [31:0] e_v);
      n_asrt++;
      assert (o_v === e_v) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, o_v, e_v);
      end
   endtask

   task automatic cyc(input string tag, input logic mr, input logic [3:0] st, input outs_t o);
      exp_t e;
      mem_ready = mr;
      sb.push_back('{st, o, ret_m});
      @(negedge clk);
      e = sb.pop_front();
      chk({tag, ".state"},   32'(state), 32'(e.st));
      chk({tag, ".outs"},    32'(obs),   32'(e.o));
      chk({tag, ".retired"}, retired,    e.ret);
      if (o.instr_done) ret_m = ret_m + 32'd1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: observed no finish expected finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; opcode = 6'b000000; zero = 1'b0; mem_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst.state", 32'(state), 32'd0);
      chk("rst.outs", 32'(obs), 32'(O_NONE));
      chk("rst.retired", retired, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // RTYPE, mem_ready tied high: 1,2,7,8 then back to 1
      opcode = 6'b000000;
      cyc("r.fetch", 1'b1, 4'd1, O_FG);
      cyc("r.dec",   1'b1, 4'd2, O_DEC);
      cyc("r.exec",  1'b1, 4'd7, O_EX);
      cyc("r.wb",    1'b1, 4'd8, O_RW);

      // LW with three wait cycles in MEM_RD; ready lands on the timeout cycle
      opcode = 6'b100011;
      cyc("lw.fetch", 1'b1, 4'd1, O_FG);
      cyc("lw.dec",   1'b1, 4'd2, O_DEC);
      cyc("lw.addr",  1'b1, 4'd3, O_MA);
      cyc("lw.rd1",   1'b0, 4'd4, O_RD);
      cyc("lw.rd2",   1'b0, 4'd4, O_RD);
      cyc("lw.rd3",   1'b0, 4'd4, O_RD);
      cyc("lw.rd4",   1'b1, 4'd4, O_RD);
      cyc("lw.wb",    1'b1, 4'd5, O_WB);

      // SW
      opcode = 6'b101011;
      cyc("sw.fetch", 1'b1, 4'd1, O_FG);
      cyc("sw.dec",   1'b1, 4'd2, O_DEC);
      cyc("sw.addr",  1'b1, 4'd3, O_MA);
      cyc("sw.wr",    1'b1, 4'd6, O_WRG);

      // BEQ taken then not taken
      opcode = 6'b000100;
      cyc("beq1.fetch", 1'b1, 4'd1, O_FG);
      cyc("beq1.dec",   1'b1, 4'd2, O_DEC);
      zero = 1'b1;
      cyc("beq1.br",    1'b1, 4'd9, O_B1);
      cyc("beq0.fetch", 1'b1, 4'd1, O_FG);
      cyc("beq0.dec",   1'b1, 4'd2, O_DEC);
      zero = 1'b0;
      cyc("beq0.br",    1'b1, 4'd9, O_B0);

      // NOP retires from DECODE
      opcode = 6'b100000;
      cyc("nop.fetch", 1'b1, 4'd1, O_FG);
      cyc("nop.dec",   1'b1, 4'd2, O_NOP);

      // Unrecognised opcode: illegal pulse, no retire
      opcode = 6'b111111;
      cyc("ill.fetch", 1'b1, 4'd1, O_FG);
      cyc("ill.dec",   1'b1, 4'd2, O_ILL);

      // J
      opcode = 6'b000010;
      cyc("j.fetch", 1'b1, 4'd1, O_FG);
`ifdef JUMP_EN
      cyc("j.dec",   1'b1, 4'd2, O_DEC);
      cyc("j.jump",  1'b1, 4'd10, O_J);
`else
      cyc("j.dec",   1'b1, 4'd2, O_ILL);
`endif

      // FETCH watchdog: abort on the 4th wait cycle, twice in a row
      opcode = 6'b101011;
      cyc("wdf.w1", 1'b0, 4'd1, O_FW);
      cyc("wdf.w2", 1'b0, 4'd1, O_FW);
      cyc("wdf.w3", 1'b0, 4'd1, O_FW);
      cyc("wdf.to", 1'b0, 4'd1, O_FT);
      cyc("wdf.w5", 1'b0, 4'd1, O_FW);
      cyc("wdf.w6", 1'b0, 4'd1, O_FW);
      cyc("wdf.w7", 1'b0, 4'd1, O_FW);
      cyc("wdf.t2", 1'b0, 4'd1, O_FT);

      // MEM_WR watchdog abort: no retire
      cyc("wdw.fetch", 1'b1, 4'd1, O_FG);
      cyc("wdw.dec",   1'b1, 4'd2, O_DEC);
      cyc("wdw.addr",  1'b1, 4'd3, O_MA);
      cyc("wdw.w1",    1'b0, 4'd6, O_WR);
      cyc("wdw.w2",    1'b0, 4'd6, O_WR);
      cyc("wdw.w3",    1'b0, 4'd6, O_WR);
      cyc("wdw.to",    1'b0, 4'd6, O_WRT);

      // Reset asserted during MEM_WR
      cyc("rw.fetch", 1'b1, 4'd1, O_FG);
      cyc("rw.dec",   1'b1, 4'd2, O_DEC);
      cyc("rw.addr",  1'b1, 4'd3, O_MA);
      cyc("rw.w1",    1'b0, 4'd6, O_WR);
      rst_n = 1'b0;
      #1;
      chk("rw.async.state",   32'(state), 32'd0);
      chk("rw.async.outs",    32'(obs),   32'(O_NONE));
      chk("rw.async.retired", retired,    32'd0);
      ret_m = '0;
      @(negedge clk);
      rst_n = 1'b1;
      mem_ready = 1'b1;
      #1;
      chk("rw.idle.state", 32'(state), 32'd0);
      chk("rw.idle.outs",  32'(obs),   32'(O_NONE));
      @(posedge clk); #1;

      // RTYPE after reset: retired 0 -> 1
      opcode = 6'b000000;
      cyc("r2.fetch", 1'b1, 4'd1, O_FG);
      cyc("r2.dec",   1'b1, 4'd2, O_DEC);
      cyc("r2.exec",  1'b1, 4'd7, O_EX);
      cyc("r2.wb",    1'b1, 4'd8, O_RW);
      cyc("r2.next",  1'b0, 4'd1, O_FW);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end

endmodule
